// File: rtl/c15xx_head_pos.sv
// c15xx_head_pos: stepper-phase decode into a clamped half-track, head settle timer,
// and a 2-deep track save FIFO with level req/ack toward the SD track loader.
module c15xx_head_pos #(
  parameter int HT_BITS    = 7,
  parameter int MAX_HT     = 80,
  parameter int RESET_HT   = 36,
  parameter int SIDES      = 1,
  parameter int SETTLE_CYC = 4096,
  parameter int SETTLE_W   = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               mtr,
  input  logic [1:0]         stp,
  input  logic               side_i,
  input  logic               act,
  input  logic               we,
  input  logic               img_mounted,
  input  logic               save_ack,
  output logic [HT_BITS-1:0] halftrack,
  output logic [HT_BITS-2:0] track,
  output logic               side_o,
  output logic               tr00_n,
  output logic               settling,
  output logic               save_req,
  output logic [HT_BITS-2:0] save_track,
  output logic               save_side,
  output logic               save_ovf,
  output logic               step_err
);
  logic [HT_BITS-1:0]  ht_q, ht_d;
  logic [1:0]          stp_q, delta;
  logic [SETTLE_W-1:0] set_q, set_d;
  logic                side_q, side_d, dirty_q, dirty_d, ovf_q, ovf_d, err_q, err_d;
  logic [HT_BITS-1:0]  ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]          cnt_q, cnt_d, cnt_pop;
  logic                inc, dec, moved, side_ev, trig, pop, full, push;
  always_comb begin
    delta   = stp - stp_q;
    inc     = mtr & (delta == 2'd1) & (ht_q != HT_BITS'(MAX_HT));
    dec     = mtr & (delta == 2'd3) & (ht_q != '0);
    moved   = inc | dec;
    ht_d    = inc ? ht_q + 1'b1 : dec ? ht_q - 1'b1 : ht_q;
    err_d   = mtr & (delta == 2'd2);
    set_d   = moved ? SETTLE_W'(SETTLE_CYC) : (ce && set_q != '0) ? set_q - 1'b1 : set_q;
    side_d  = (SIDES == 2) ? side_i : 1'b0;
    side_ev = side_d != side_q;
    pop     = save_ack & (cnt_q != 2'd0);
    cnt_pop = cnt_q - {1'b0, pop};
    trig    = dirty_q & (moved | side_ev | ~act) & ~img_mounted;
    full    = cnt_pop == 2'd2;
    push    = trig & ~full;
    ovf_d   = trig & full;
    // entries hold {track, side} as they were before the triggering event
    ent0_d  = pop ? ent1_q : ent0_q;
    ent1_d  = ent1_q;
    if (push && cnt_pop == 2'd0) ent0_d = {track, side_q};
    if (push && cnt_pop != 2'd0) ent1_d = {track, side_q};
    cnt_d   = img_mounted ? 2'd0 : cnt_pop + {1'b0, push};
    dirty_d = img_mounted ? 1'b0 : trig ? we : dirty_q | we;
  end
  always_ff @(posedge clk) begin
    stp_q <= stp;
    if (reset) begin
      ht_q    <= HT_BITS'(RESET_HT);
      set_q   <= '0;
      side_q  <= 1'b0;
      dirty_q <= 1'b0;
      cnt_q   <= 2'd0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      ht_q    <= ht_d;
      set_q   <= set_d;
      side_q  <= side_d;
      dirty_q <= dirty_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end
  assign halftrack  = ht_q;
  assign track      = ht_q[HT_BITS-1:1];
  assign side_o     = side_q;
  assign tr00_n     = |track;
  assign settling   = |set_q;
  assign save_req   = cnt_q != 2'd0;
  assign save_track = ent0_q[HT_BITS-1:1];
  assign save_side  = ent0_q[0];
  assign save_ovf   = ovf_q;
  assign step_err   = err_q;
endmodule

// File: tb/tb_c15xx_head_pos.sv
// tb_c15xx_head_pos: single- and dual-side instances checked against a behavioural model,
// table vectors, hand-written corner sequences and randomized traffic.
module tb_c15xx_head_pos;
  logic clk = 1'b0;
  logic reset, ce, mtr, side_i, act, we, img_mounted, save_ack;
  logic [1:0] stp;
  logic [6:0] ht_a, ht_b;
  logic [5:0] tr_a, tr_b, stk_a, stk_b;
  logic so_a, so_b, t0_a, t0_b, se_a, se_b, rq_a, rq_b, ssd_a, ssd_b, ov_a, ov_b, er_a, er_b;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  c15xx_head_pos #(.SIDES(1)) dut_a (
    .clk(clk), .reset(reset), .ce(ce), .mtr(mtr), .stp(stp), .side_i(side_i), .act(act),
    .we(we), .img_mounted(img_mounted), .save_ack(save_ack), .halftrack(ht_a), .track(tr_a),
    .side_o(so_a), .tr00_n(t0_a), .settling(se_a), .save_req(rq_a), .save_track(stk_a),
    .save_side(ssd_a), .save_ovf(ov_a), .step_err(er_a));

  c15xx_head_pos #(.SIDES(2)) dut_b (
    .clk(clk), .reset(reset), .ce(ce), .mtr(mtr), .stp(stp), .side_i(side_i), .act(act),
    .we(we), .img_mounted(img_mounted), .save_ack(save_ack), .halftrack(ht_b), .track(tr_b),
    .side_o(so_b), .tr00_n(t0_b), .settling(se_b), .save_req(rq_b), .save_track(stk_b),
    .save_side(ssd_b), .save_ovf(ov_b), .step_err(er_b));

  typedef struct { int ht; int old; int settle; int side; int dirty; int ovf; int err; int n; int e[2]; } mdl_t;
  mdl_t ma, mb;

  function automatic mdl_t mstep(mdl_t s, int sides);
    mdl_t r;
    int d, sd, moved, trig;
    r = s;
    if (reset) begin
      r.ht = 36; r.old = int'(stp); r.settle = 0; r.side = 0; r.dirty = 0;
      r.ovf = 0; r.err = 0; r.n = 0;
      return r;
    end
    d = (int'(stp) - s.old + 4) % 4;
    sd = (sides == 2) ? int'(side_i) : 0;
    moved = 0;
    if (mtr && d == 1 && s.ht < 80) begin r.ht = s.ht + 1; moved = 1; end
    if (mtr && d == 3 && s.ht > 0) begin r.ht = s.ht - 1; moved = 1; end
    r.old = int'(stp);
    r.err = (mtr && d == 2) ? 1 : 0;
    r.side = sd;
    r.ovf = 0;
    r.settle = moved != 0 ? 4096 : (ce && s.settle > 0) ? s.settle - 1 : s.settle;
    if (save_ack && s.n > 0) begin r.e[0] = s.e[1]; r.n = s.n - 1; end
    trig = (s.dirty != 0 && (moved != 0 || sd != s.side || !act)) ? 1 : 0;
    if (img_mounted) begin
      r.n = 0; r.dirty = 0;
    end else if (trig != 0) begin
      if (r.n < 2) begin r.e[r.n] = (s.ht / 2) * 2 + s.side; r.n = r.n + 1; end
      else r.ovf = 1;
      r.dirty = int'(we);
    end else r.dirty = (s.dirty != 0 || we) ? 1 : 0;
    return r;
  endfunction

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp_one(string tag, mdl_t m, logic [6:0] ht, logic [5:0] tr, logic so, logic t0,
                         logic se, logic rq, logic [5:0] stk, logic ssd, logic ov, logic er);
    chk({tag, ".halftrack"}, int'(ht), m.ht);
    chk({tag, ".track"}, int'(tr), m.ht / 2);
    chk({tag, ".side_o"}, int'(so), m.side);
    chk({tag, ".tr00_n"}, int'(t0), (m.ht / 2) != 0 ? 1 : 0);
    chk({tag, ".settling"}, int'(se), m.settle > 0 ? 1 : 0);
    chk({tag, ".save_req"}, int'(rq), m.n > 0 ? 1 : 0);
    if (m.n > 0) begin
      chk({tag, ".save_track"}, int'(stk), m.e[0] / 2);
      chk({tag, ".save_side"}, int'(ssd), m.e[0] % 2);
    end
    chk({tag, ".save_ovf"}, int'(ov), m.ovf);
    chk({tag, ".step_err"}, int'(er), m.err);
  endtask

  task automatic tick();
    @(posedge clk);
    ma = mstep(ma, 1);
    mb = mstep(mb, 2);
    #1;
    cmp_one("A", ma, ht_a, tr_a, so_a, t0_a, se_a, rq_a, stk_a, ssd_a, ov_a, er_a);
    cmp_one("B", mb, ht_b, tr_b, so_b, t0_b, se_b, rq_b, stk_b, ssd_b, ov_b, er_b);
  endtask

  task automatic step(int dir);
    stp = stp + 2'(dir);
    tick();
  endtask

  task automatic write_pulse();
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  typedef struct { logic m; logic [1:0] s; int ht; int trk; int err; } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, 2'd1, 37, 18, 0};
    tbl[1] = '{1'b1, 2'd2, 38, 19, 0};
    tbl[2] = '{1'b1, 2'd3, 39, 19, 0};
    tbl[3] = '{1'b1, 2'd1, 39, 19, 1};
    tbl[4] = '{1'b1, 2'd1, 39, 19, 0};
    tbl[5] = '{1'b1, 2'd0, 38, 19, 0};
    tbl[6] = '{1'b0, 2'd2, 38, 19, 0};
    tbl[7] = '{1'b0, 2'd3, 38, 19, 0};
    tbl[8] = '{1'b1, 2'd0, 39, 19, 0};
    reset = 1'b1; ce = 1'b1; mtr = 1'b1; stp = 2'd0; side_i = 1'b0; act = 1'b1;
    we = 1'b0; img_mounted = 1'b0; save_ack = 1'b0;
    #2;
    tick();
    chk("reset_ht", int'(ht_b), 36);
    chk("reset_req", int'(rq_b), 0);
    chk("reset_settling", int'(se_b), 0);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      mtr = tbl[i].m;
      stp = tbl[i].s;
      tick();
      chk("vec_ht", int'(ht_b), tbl[i].ht);
      chk("vec_track", int'(tr_b), tbl[i].trk);
      chk("vec_err", int'(er_b), tbl[i].err);
      chk("vec_settling", int'(se_b), 1);
    end
    mtr = 1'b1;
    repeat (4095) tick();
    chk("settle_4095", int'(se_b), 1);
    tick();
    chk("settle_4096", int'(se_b), 0);

    repeat (41) step(1);
    chk("at_max", int'(ht_b), 80);
    repeat (4096) tick();
    step(1);
    chk("clamp_max_ht", int'(ht_b), 80);
    chk("clamp_max_settle", int'(se_b), 0);
    repeat (80) step(-1);
    repeat (4096) tick();
    step(-1);
    chk("clamp_zero_ht", int'(ht_b), 0);
    chk("clamp_zero_settle", int'(se_b), 0);
    chk("clamp_zero_tr00", int'(t0_b), 0);

    reset = 1'b1; tick(); reset = 1'b0;
    write_pulse();
    step(1);
    chk("save_req", int'(rq_b), 1);
    chk("save_track", int'(stk_b), 18);
    chk("save_side", int'(ssd_b), 0);
    save_ack = 1'b1; tick(); save_ack = 1'b0;
    chk("save_ack_req", int'(rq_b), 0);

    write_pulse(); step(1);
    write_pulse(); step(1);
    write_pulse(); step(1);
    chk("ovf_pulse", int'(ov_b), 1);
    chk("ovf_head", int'(stk_b), 18);
    tick();
    chk("ovf_clear", int'(ov_b), 0);
    save_ack = 1'b1;
    tick();
    chk("pop1_req", int'(rq_b), 1);
    chk("pop1_track", int'(stk_b), 19);
    tick();
    chk("pop2_req", int'(rq_b), 0);
    save_ack = 1'b0;

    write_pulse();
    side_i = 1'b1; tick();
    chk("side_req", int'(rq_b), 1);
    chk("side_entry_side", int'(ssd_b), 0);
    chk("side_entry_track", int'(stk_b), 20);
    chk("side_o", int'(so_b), 1);
    save_ack = 1'b1; tick(); save_ack = 1'b0;
    write_pulse();
    act = 1'b0; tick(); act = 1'b1;
    chk("act_req", int'(rq_b), 1);
    chk("act_side", int'(ssd_b), 1);
    chk("act_track", int'(stk_b), 20);
    save_ack = 1'b1; tick(); save_ack = 1'b0;

    write_pulse(); step(1);
    chk("img_pre_req", int'(rq_b), 1);
    img_mounted = 1'b1; tick(); img_mounted = 1'b0;
    chk("img_req", int'(rq_b), 0);
    save_ack = 1'b1; tick(); save_ack = 1'b0;
    chk("img_ack_ignored", int'(rq_b), 0);

    side_i = 1'b0;
    write_pulse(); step(1);
    write_pulse(); step(1);
    chk("midq_req", int'(rq_b), 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midq_reset_req", int'(rq_b), 0);
    chk("midq_reset_ht", int'(ht_b), 36);
    tick();
    chk("midq_after_req", int'(rq_b), 0);

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      img_mounted = ($urandom_range(0, 39) == 0);
      we = ($urandom_range(0, 3) == 0);
      act = ($urandom_range(0, 7) != 0);
      mtr = ($urandom_range(0, 7) != 0);
      ce = ($urandom_range(0, 1) == 0);
      save_ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) side_i = ~side_i;
      if ($urandom_range(0, 2) == 0) stp = stp + 2'($urandom_range(0, 3));
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
